// File: rtl/key_matrix_scan.sv
// key_matrix_scan: column-scanned key matrix controller (up to 8 rows x 16 columns).
// Drives one column low at a time and samples the active-low row lines. A single
// pressed key is debounced over whole scan frames. Press, typematic-repeat and
// release events are queued in a FIFO for the host.
//
// Ports:
//   clk_1mhz      system clock
//   reset_n       asynchronous active-low reset
//   key_in        row sense lines, 0 = closed on the driven column
//   key_out       column drives, exactly one bit low
//   key_rd        pop strobe for the FIFO head
//   clr_ovf       clear strobe for the overflow flag
//   key_valid     FIFO non-empty
//   key_code_out  FIFO head {release, row[2:0], col[3:0]}, 8'hFF when empty
//   irq_key       active-low interrupt, !key_valid
//   key_ovf       sticky: an event was dropped on a full FIFO
module key_matrix_scan #(
    parameter int unsigned ROWS        = 4,
    parameter int unsigned COLS        = 4,
    parameter int unsigned SCAN_DIV    = 2000,
    parameter int unsigned DEBOUNCE    = 3,
    parameter int unsigned FIFO_DEPTH  = 8,
    parameter int unsigned REPEAT_DLY  = 63,
    parameter int unsigned REPEAT_RATE = 12
) (
    input  logic            clk_1mhz,
    input  logic            reset_n,
    input  logic [ROWS-1:0] key_in,
    output logic [COLS-1:0] key_out,
    input  logic            key_rd,
    input  logic            clr_ovf,
    output logic            key_valid,
    output logic [7:0]      key_code_out,
    output logic            irq_key,
    output logic            key_ovf
);
    localparam int unsigned PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned CW = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned RW = 16;

    typedef enum logic [1:0] {StIdle, StPressDb, StHeld, StReleaseDb} state_e;

    logic [PW-1:0] pre_q, pre_d;
    logic [CW-1:0] col_q, col_d;
    logic          tick, frame_end;

    // Per-frame closure accumulator: count saturates at 2 (= MULTI).
    logic [1:0] fr_n_q, fr_n_d, col_n, acc_n;
    logic [6:0] fr_code_q, fr_code_d, acc_code;
    logic [2:0] col_row;

    state_e          st_q, st_d;
    logic [6:0]      cand_q, cand_d;
    logic [3:0]      cnt_q, cnt_d, cnt_inc;
    logic [RW-1:0]   rep_q, rep_d, rep_inc, rep_lim;
    logic            rep_ph_q, rep_ph_d;
    logic            hit, res_key, res_multi;
    logic            push;
    logic [7:0]      push_code;

    logic [7:0]      mem_q [FIFO_DEPTH];
    logic [AW-1:0]   wptr_q, rptr_q;
    logic [AW:0]     fcnt_q, fcnt_d;
    logic            ovf_q, ovf_d;
    logic            empty, full, pop, wr;

    // Scan timing
    assign tick      = (pre_q == PW'(SCAN_DIV - 1));
    assign frame_end = tick && (col_q == CW'(COLS - 1));

    always_comb begin
        pre_d = tick ? '0 : pre_q + 1'b1;
        col_d = col_q;
        if (tick) begin
            col_d = (col_q == CW'(COLS - 1)) ? '0 : col_q + 1'b1;
        end
    end

    always_comb begin
        key_out        = '1;
        key_out[col_q] = 1'b0;
    end

    // Closures on the driven column; lowest closed row gives the row index.
    always_comb begin
        col_n   = 2'd0;
        col_row = 3'd0;
        for (int unsigned r = 0; r < ROWS; r++) begin
            if (!key_in[r]) begin
                if (col_n == 2'd0) col_row = 3'(r);
                if (col_n != 2'd2) col_n = col_n + 2'd1;
            end
        end
        if (fr_n_q == 2'd0)     acc_n = col_n;
        else if (col_n == 2'd0) acc_n = fr_n_q;
        else                    acc_n = 2'd2;
        acc_code = (fr_n_q != 2'd0) ? fr_code_q : {col_row, 4'(col_q)};
        fr_n_d    = fr_n_q;
        fr_code_d = fr_code_q;
        if (frame_end) begin
            fr_n_d    = 2'd0;
            fr_code_d = '0;
        end else if (tick) begin
            fr_n_d    = acc_n;
            fr_code_d = acc_code;
        end
    end

    assign res_key   = (acc_n == 2'd1);
    assign res_multi = (acc_n == 2'd2);
    assign hit       = res_key && (acc_code == cand_q);
    assign cnt_inc   = cnt_q + 4'd1;
    assign rep_inc   = rep_q + 1'b1;
    assign rep_lim   = rep_ph_q ? RW'(REPEAT_RATE) : RW'(REPEAT_DLY);

    // Debounce / typematic FSM, advanced only at frame end
    always_comb begin
        st_d      = st_q;
        cand_d    = cand_q;
        cnt_d     = cnt_q;
        rep_d     = rep_q;
        rep_ph_d  = rep_ph_q;
        push      = 1'b0;
        push_code = {1'b0, cand_q};
        if (frame_end) begin
            case (st_q)
                StIdle: begin
                    if (res_key) begin
                        cand_d = acc_code;
                        if (DEBOUNCE == 1) begin
                            push      = 1'b1;
                            push_code = {1'b0, acc_code};
                            rep_d     = '0;
                            rep_ph_d  = 1'b0;
                            st_d      = StHeld;
                        end else begin
                            cnt_d = 4'd1;
                            st_d  = StPressDb;
                        end
                    end
                end
                StPressDb: begin
                    if (hit) begin
                        if (cnt_inc == 4'(DEBOUNCE)) begin
                            push     = 1'b1;
                            rep_d    = '0;
                            rep_ph_d = 1'b0;
                            st_d     = StHeld;
                        end else begin
                            cnt_d = cnt_inc;
                        end
                    end else if (!res_multi) begin
                        st_d = StIdle;
                    end
                end
                StHeld: begin
                    if (hit) begin
                        if (REPEAT_DLY != 0) begin
                            // First repeat after REPEAT_DLY frames, then every REPEAT_RATE.
                            if (rep_inc == rep_lim) begin
                                push     = 1'b1;
                                rep_d    = '0;
                                rep_ph_d = 1'b1;
                            end else begin
                                rep_d = rep_inc;
                            end
                        end
                    end else if (!res_multi) begin
                        if (DEBOUNCE == 1) begin
                            push      = 1'b1;
                            push_code = {1'b1, cand_q};
                            st_d      = StIdle;
                        end else begin
                            cnt_d = 4'd1;
                            st_d  = StReleaseDb;
                        end
                    end
                end
                StReleaseDb: begin
                    if (hit) begin
                        st_d = StHeld;
                    end else if (!res_multi) begin
                        if (cnt_inc == 4'(DEBOUNCE)) begin
                            push      = 1'b1;
                            push_code = {1'b1, cand_q};
                            st_d      = StIdle;
                        end else begin
                            cnt_d = cnt_inc;
                        end
                    end
                end
                default: st_d = StIdle;
            endcase
        end
    end

    // Event FIFO
    assign empty = (fcnt_q == '0);
    assign full  = (fcnt_q == (AW + 1)'(FIFO_DEPTH));
    assign pop   = key_rd && !empty;
    assign wr    = push && (!full || pop);

    always_comb begin
        fcnt_d = fcnt_q;
        if (wr && !pop)      fcnt_d = fcnt_q + 1'b1;
        else if (pop && !wr) fcnt_d = fcnt_q - 1'b1;
        // A dropped push takes priority over a coincident clear.
        if (push && full && !pop) ovf_d = 1'b1;
        else if (clr_ovf)         ovf_d = 1'b0;
        else                      ovf_d = ovf_q;
    end

    assign key_valid    = !empty;
    assign irq_key      = empty;
    assign key_code_out = empty ? 8'hFF : mem_q[rptr_q];
    assign key_ovf      = ovf_q;

    always_ff @(posedge clk_1mhz or negedge reset_n) begin
        if (!reset_n) begin
            pre_q     <= '0;
            col_q     <= '0;
            fr_n_q    <= '0;
            fr_code_q <= '0;
            st_q      <= StIdle;
            cand_q    <= '0;
            cnt_q     <= '0;
            rep_q     <= '0;
            rep_ph_q  <= 1'b0;
            mem_q     <= '{default: '0};
            wptr_q    <= '0;
            rptr_q    <= '0;
            fcnt_q    <= '0;
            ovf_q     <= 1'b0;
        end else begin
            pre_q     <= pre_d;
            col_q     <= col_d;
            fr_n_q    <= fr_n_d;
            fr_code_q <= fr_code_d;
            st_q      <= st_d;
            cand_q    <= cand_d;
            cnt_q     <= cnt_d;
            rep_q     <= rep_d;
            rep_ph_q  <= rep_ph_d;
            fcnt_q    <= fcnt_d;
            ovf_q     <= ovf_d;
            if (wr) begin
                mem_q[wptr_q] <= push_code;
                wptr_q        <= wptr_q + 1'b1;
            end
            if (pop) rptr_q <= rptr_q + 1'b1;
        end
    end

endmodule
